// File: rtl/pipe_pkg.sv
// Shared widths and occupancy encoding for the pipeline stage register.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_t;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag plus payload, with load and clear.
// Clear drops valid and zeroes ctrl (bubble = NOP) but keeps data.
module pipe_slot #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d_data;
      ctrl  <= d_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush. Define PIPE_SKID_EN for a
// 2-entry skid buffer with registered in_ready; otherwise a single entry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occ
);

  logic              main_load;
  logic              main_clear;
  logic [DATA_W-1:0] main_d_data;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic              accept;
  logic              drain;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (main_load),
    .clear  (main_clear),
    .d_data (main_d_data),
    .d_ctrl (main_d_ctrl),
    .valid  (out_valid),
    .data   (out_data),
    .ctrl   (out_ctrl)
  );

`ifdef PIPE_SKID_EN

  occ_state_t        state_reg, state_next;
  logic              in_ready_reg;
  logic              skid_load;
  logic              skid_clear;
  logic              main_sel_skid;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (skid_load),
    .clear  (skid_clear),
    .d_data (in_data),
    .d_ctrl (in_ctrl),
    .valid  (skid_valid),
    .data   (skid_data),
    .ctrl   (skid_ctrl)
  );

  // in_ready is registered from the next state, so out_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != FULL);
    end
  end

  always_comb begin
    state_next    = state_reg;
    main_load     = 1'b0;
    main_clear    = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    if (flush) begin
      state_next = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            main_load  = 1'b1;
            state_next = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load  = 1'b1;
            state_next = FULL;
          end else if (drain) begin
            main_clear = 1'b1;
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
            skid_clear    = 1'b1;
            state_next    = ONE;
          end
        end
        default: begin
          state_next = EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_d_data = main_sel_skid ? skid_data : in_data;
  assign main_d_ctrl = main_sel_skid ? skid_ctrl : in_ctrl;
  assign in_ready    = in_ready_reg;
  assign occ         = state_reg;

  logic unused_skid;
  assign unused_skid = skid_valid;

`else

  assign in_ready    = !out_valid || out_ready;
  assign main_load   = !flush && accept;
  assign main_clear  = flush || (drain && !accept);
  assign main_d_data = in_data;
  assign main_d_ctrl = in_ctrl;
  assign occ         = {1'b0, out_valid};

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; covers both builds.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [15:0] in_ctrl;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_ctrl;
  logic [1:0]  occ;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occ       (occ)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [31:0] d, input logic [15:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] d,
                            input logic [15:0] c, input logic [1:0] o);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    check({tag, ".out_data"},  64'(out_data),  64'(d));
    check({tag, ".out_ctrl"},  64'(out_ctrl),  64'(c));
    check({tag, ".occ"},       64'(occ),       64'(o));
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    beat(1'b1, 32'h99, 16'hFFFF);
    #1;

    // Reset held two cycles with a live input beat
    tick();
    tick();
    expect_out("reset", 1'b0, 32'h0, 16'h0, 2'd0);
    rst_n = 1'b1;
    beat(1'b0, 32'h0, 16'h0);
    #1;
    check("reset.in_ready", 64'(in_ready), 64'd1);

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, 32'h10 + 32'(i), 16'h8010 + 16'(i));
      tick();
      expect_out($sformatf("stream%0d", i), 1'b1, 32'h10 + 32'(i), 16'h8010 + 16'(i), 2'd1);
    end
    beat(1'b0, 32'h0, 16'h0);
    tick();
    expect_out("stream_end", 1'b0, 32'h17, 16'h0, 2'd0);

`ifdef PIPE_SKID_EN
    // Backpressure into the skid entry
    beat(1'b1, 32'hA0, 16'h80A0);
    tick();
    expect_out("bp_a0", 1'b1, 32'hA0, 16'h80A0, 2'd1);
    out_ready = 1'b0;
    beat(1'b1, 32'hA1, 16'h80A1);
    tick();
    expect_out("bp_full", 1'b1, 32'hA0, 16'h80A0, 2'd2);
    check("bp_full.in_ready", 64'(in_ready), 64'd0);
    beat(1'b1, 32'hA2, 16'h80A2);
    tick();
    expect_out("bp_hold", 1'b1, 32'hA0, 16'h80A0, 2'd2);
    check("bp_hold.in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    expect_out("bp_a1", 1'b1, 32'hA1, 16'h80A1, 2'd1);
    check("bp_a1.in_ready", 64'(in_ready), 64'd1);
    tick();
    expect_out("bp_a2", 1'b1, 32'hA2, 16'h80A2, 2'd1);
    beat(1'b0, 32'h0, 16'h0);
    tick();
    expect_out("bp_drain", 1'b0, 32'hA2, 16'h0, 2'd0);

    // Fill to two entries ahead of the flush
    beat(1'b1, 32'hB0, 16'h80B0);
    tick();
    out_ready = 1'b0;
    beat(1'b1, 32'hB1, 16'h80B1);
    tick();
    check("pre_flush.occ", 64'(occ), 64'd2);
`else
    // Backpressure on the single entry; in_ready tracks out_ready combinationally
    out_ready = 1'b0;
    beat(1'b1, 32'hC0, 16'h80C0);
    tick();
    expect_out("bp_c0", 1'b1, 32'hC0, 16'h80C0, 2'd1);
    check("bp_c0.in_ready", 64'(in_ready), 64'd0);
    beat(1'b1, 32'hC1, 16'h80C1);
    tick();
    expect_out("bp_hold", 1'b1, 32'hC0, 16'h80C0, 2'd1);
    out_ready = 1'b1;
    #1;
    check("comb.in_ready_hi", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
    #1;
    check("comb.in_ready_lo", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    expect_out("bp_c1", 1'b1, 32'hC1, 16'h80C1, 2'd1);
    out_ready = 1'b0;
    check("pre_flush.occ", 64'(occ), 64'd1);
`endif

    // Flush with a simultaneous input beat
    flush     = 1'b1;
    out_ready = 1'b1;
    beat(1'b1, 32'hBB, 16'h80BB);
    tick();
    check("flush.out_valid", 64'(out_valid), 64'd0);
    check("flush.out_ctrl",  64'(out_ctrl),  64'd0);
    check("flush.occ",       64'(occ),       64'd0);
    check("flush.in_ready",  64'(in_ready),  64'd1);
    flush = 1'b0;
    beat(1'b0, 32'h0, 16'h0);
    tick();
    check("post_flush.out_valid", 64'(out_valid), 64'd0);
    check("post_flush.no_bb", 64'(out_data == 32'hBB), 64'd0);

    // Accept and release in the same cycle at one entry
    beat(1'b1, 32'h55, 16'h8055);
    tick();
    expect_out("swap_55", 1'b1, 32'h55, 16'h8055, 2'd1);
    beat(1'b1, 32'h66, 16'h8066);
    tick();
    expect_out("swap_66", 1'b1, 32'h66, 16'h8066, 2'd1);
    beat(1'b0, 32'h0, 16'h0);
    tick();
    expect_out("swap_end", 1'b0, 32'h66, 16'h0, 2'd0);

    // Reset mid-operation wins over flush and clears data
    out_ready = 1'b0;
    beat(1'b1, 32'h77, 16'h8077);
    tick();
    expect_out("mid_77", 1'b1, 32'h77, 16'h8077, 2'd1);
    rst_n = 1'b0;
    flush = 1'b1;
    tick();
    expect_out("mid_reset", 1'b0, 32'h0, 16'h0, 2'd0);
    rst_n = 1'b1;
    flush = 1'b0;
    beat(1'b0, 32'h0, 16'h0);
    #1;
    check("mid_reset.in_ready", 64'(in_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning payload width (operands, immediates, addresses).
REQ-002 The block SHALL have parameter CTRL_W, default 16, meaning control-bit width (RegWrite, MemWrite, ALUOp, ...), zeroed on bubbles.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset: clk input 1 (all state on posedge); rst_n input 1 (synchronous, active-low).
REQ-004 The block SHALL have these ports:
- in_valid input 1: upstream beat present.
- in_ready output 1: stage can accept.
- in_data input DATA_W.
- in_ctrl input CTRL_W.
- flush input 1: kill stage contents (branch/jump squash).
- out_valid output 1.
- out_ready input 1: downstream can accept.
- out_data output DATA_W.
- out_ctrl output CTRL_W.
- occ output 2: current entry count, 0..2.

Function
REQ-005 A beat SHALL transfer in when in_valid&&in_ready at posedge clk, and out when out_valid&&out_ready.
REQ-006 Latency SHALL be 1 cycle: a beat accepted at edge N is on out_* after edge N when the stage was empty.
REQ-007 out_ctrl SHALL be all-zero whenever out_valid=0 (bubble = NOP); out_data SHALL hold its last value when not valid.
REQ-008 While out_valid=1 and out_ready=0, out_data/out_ctrl SHALL remain stable.
REQ-009 Beats SHALL leave in acceptance order; no beat is dropped or duplicated except by flush.
REQ-010 flush=1 at an edge SHALL clear all entries (out_valid=0, occ=0, out_ctrl=0) and discard any simultaneous input beat; flush overrides in_valid and out_ready.
REQ-011 Simultaneous accept and release at occ=1 SHALL replace the entry with the new beat; occ stays 1.
REQ-012 in_valid and in_data SHALL be ignored when in_ready=0.
REQ-013 With skid (REQ-017), the state machine SHALL be EMPTY(occ0), ONE(occ1), FULL(occ2):
- EMPTY->ONE on accept.
- ONE->FULL on accept without release.
- ONE->EMPTY on release without accept.
- FULL->ONE on release (no accept possible).
- Any->EMPTY on flush.

Reset
REQ-014 While rst_n=0 at an edge, the block SHALL set out_valid=0, out_ctrl=0, out_data=0, occ=0 and clear the skid entry.
REQ-015 The first edge with rst_n=1 SHALL be able to accept a beat (in_ready=1 out of reset).
REQ-016 Reset mid-operation SHALL discard all held beats, identical to flush, and take priority over flush.

Configuration
REQ-017 Macro PIPE_SKID_EN defined SHALL give a 2-entry skid buffer:
- in_ready is a flop output, =1 iff occ<2.
- No combinational path from out_ready to in_ready.
- Full throughput, with the skid entry absorbing one beat when out_ready drops.
REQ-018 Macro PIPE_SKID_EN undefined SHALL give a single entry:
- in_ready = !out_valid || out_ready (combinational).
- occ never exceeds 1.
- All other REQs hold.

Structure
REQ-019 A shared package pipe_pkg SHALL hold default widths (DATA_W_DEF=32, CTRL_W_DEF=16) and the occupancy state encoding (EMPTY=0, ONE=1, FULL=2).
REQ-020 One sub-module pipe_slot (a single valid+data+ctrl register with load/clear) SHALL be instantiated once for the main entry and once more for the skid entry under PIPE_SKID_EN.

Verification
REQ-021 Reset: hold rst_n=0 for 2 cycles with in_valid=1 and in_ctrl=16'hFFFF -> out_valid=0, out_ctrl=0, occ=0; in_ready=1 on the first cycle after release.
REQ-022 Streaming: 8 beats, data 0x10..0x17, out_ready=1 throughout -> each appears 1 cycle later, in order, one per cycle; occ=1 steady.
REQ-023 Backpressure (skid): stream 0xA0,0xA1,0xA2 and drop out_ready after 0xA0 is presented -> occ=2, in_ready=0, 0xA0 held stable; raise out_ready -> 0xA0,0xA1,0xA2 emerge with no loss.
REQ-024 Flush with occ=2 plus simultaneous in_valid (data 0xBB) -> next cycle out_valid=0, out_ctrl=0, occ=0; 0xBB never appears.
REQ-025 Simultaneous accept/release at occ=1 (hold 0x55, input 0x66, out_ready=1) -> 0x55 leaves, out_data=0x66 next cycle, occ=1.
REQ-026 Build without PIPE_SKID_EN: with out_valid=1, toggling out_ready in the same cycle -> in_ready follows it combinationally; occ stays ≤1.
